// File: rtl/c_state_ctrl.sv
// Phase sequencer for the VPE clock driver: SRAM load, variable broadcast, then
// whole 12-cycle processing sweeps, with registered one-hot phase outputs.
module c_state_ctrl #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned NUM_VPE = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [CNT_W-1:0] sram_len_i,
    input  logic [CNT_W-1:0] var_len_i,
    input  logic [CNT_W-1:0] sweeps_i,
    input  logic             shuffle_en_i,
    output logic             sram_state_o,
    output logic             var_state_o,
    output logic             proc_state_o,
    output logic             shuffle_o,
    output logic [3:0]       slot_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SRAM,
        S_VAR,
        S_PROC,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] var_len_q, var_len_d;
    logic [CNT_W-1:0] sweeps_q, sweeps_d;
    logic [CNT_W-1:0] sweep_q, sweep_d;
    logic [3:0]       slot_q, slot_d;
    logic             shuf_en_q, shuf_en_d;
    logic             abort_q, abort_d;
    logic             sram_state_q, var_state_q, proc_state_q;
    logic             shuffle_q, busy_q, done_q;

    // First phase with a nonzero length, so empty phases cost no cycle.
    function automatic state_e first_phase(input logic [CNT_W-1:0] s,
                                           input logic [CNT_W-1:0] v,
                                           input logic [CNT_W-1:0] w);
        if (s != '0)      return S_SRAM;
        else if (v != '0) return S_VAR;
        else if (w != '0) return S_PROC;
        else              return S_DONE;
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        var_len_d = var_len_q;
        sweeps_d  = sweeps_q;
        sweep_d   = sweep_q;
        slot_d    = slot_q;
        shuf_en_d = shuf_en_q;
        abort_d   = abort_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    var_len_d = var_len_i;
                    sweeps_d  = sweeps_i;
                    shuf_en_d = shuffle_en_i;
                    state_d   = first_phase(sram_len_i, var_len_i, sweeps_i);
                    cnt_d     = (sram_len_i != '0) ? sram_len_i : var_len_i;
                end
            end
            S_SRAM: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = first_phase('0, var_len_q, sweeps_q);
                    cnt_d   = var_len_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_VAR: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = first_phase('0, '0, sweeps_q);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_PROC: begin
                // Abort is held until the sweep wraps so the driver ends on VPE 0.
                abort_d = abort_q | abort_i;
                if (slot_q == 4'(NUM_VPE - 1)) begin
                    slot_d = '0;
                    if (abort_q || abort_i || (sweep_q == sweeps_q - CNT_W'(1)))
                        state_d = S_DONE;
                    else
                        sweep_d = sweep_q + CNT_W'(1);
                end else begin
                    slot_d = slot_q + 4'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (state_d != S_PROC) begin
            slot_d  = '0;
            sweep_d = '0;
            abort_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            var_len_q    <= '0;
            sweeps_q     <= '0;
            sweep_q      <= '0;
            slot_q       <= '0;
            shuf_en_q    <= 1'b0;
            abort_q      <= 1'b0;
            sram_state_q <= 1'b0;
            var_state_q  <= 1'b0;
            proc_state_q <= 1'b0;
            shuffle_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            var_len_q    <= var_len_d;
            sweeps_q     <= sweeps_d;
            sweep_q      <= sweep_d;
            slot_q       <= slot_d;
            shuf_en_q    <= shuf_en_d;
            abort_q      <= abort_d;
            sram_state_q <= (state_d == S_SRAM);
            var_state_q  <= (state_d == S_VAR);
            proc_state_q <= (state_d == S_PROC);
            shuffle_q    <= shuf_en_d & sweep_d[0] & (state_d == S_PROC);
            busy_q       <= (state_d == S_SRAM) || (state_d == S_VAR) || (state_d == S_PROC);
            done_q       <= (state_d == S_DONE);
        end
    end

    assign sram_state_o = sram_state_q;
    assign var_state_o  = var_state_q;
    assign proc_state_o = proc_state_q;
    assign shuffle_o    = shuffle_q;
    assign slot_o       = slot_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule
